// File: rtl/shared_reg_arbiter_pkg.sv
// Shared arbitration types: FSM state encoding and the round-robin pick
// function reused by every arbiter in the design.
package shared_reg_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit strictly after 'last', wrapping modulo n (n <= MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0]         last,
                                       input int                 n);
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      k = (int'(last) + i) % n;
      if (!r.valid && (i <= n) && req[3'(k)]) begin
        r.valid = 1'b1;
        r.idx   = 3'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_picker.sv
// Combinational round-robin picker: rotates priority to start just after
// the previous owner and returns the first active request.
module shared_reg_arbiter_rr_picker
  import shared_reg_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           pick;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    pick                 = rr_pick(req_ext, 3'(last), N_REQ);
    valid                = pick.valid;
    idx                  = IW'(pick.idx);
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin ownership arbiter guarding a shared register: one owner at a
// time, bounded hold with pre-emption, only the owner's writes land.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int DW       = 8,
  parameter  int HOLD_MAX = 4,
  localparam int OW       = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  wr_en,
  input  logic [N_REQ*DW-1:0] wr_data,
  output logic [N_REQ-1:0]  gnt,
  output logic [OW-1:0]     owner,
  output logic              busy,
  output logic [DW-1:0]     reg_q,
  output logic              wr_err
);

  localparam int            HW       = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_TOP = HW'(HOLD_MAX);

  arb_state_e         state_q, state_d;
  logic [N_REQ-1:0]   gnt_d;
  logic [OW-1:0]      owner_d;
  logic [OW-1:0]      last_q, last_d;
  logic [HW-1:0]      hold_cnt, hold_d;

  logic [N_REQ-1:0]   pick_req;
  logic [OW-1:0]      pick_last;
  logic               pick_valid;
  logic [OW-1:0]      pick_idx;
  logic               grant_pick;

  logic               wr_hit;
  logic [DW-1:0]      wr_sel;

  // While owning, the picker only sees the other requesters, rotated from the owner.
  always_comb begin
    pick_req  = (state_q == ST_OWN) ? (req & ~gnt) : req;
    pick_last = (state_q == ST_OWN) ? owner : last_q;
  end

  shared_reg_arbiter_rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req   (pick_req),
    .last  (pick_last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt;
    owner_d    = owner;
    last_d     = last_q;
    hold_d     = hold_cnt;
    grant_pick = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) grant_pick = 1'b1;
      end
      ST_OWN: begin
        if (!req[owner]) begin
          last_d = owner;
          if (pick_valid) begin
            grant_pick = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (pick_valid && (hold_cnt == HOLD_TOP)) begin
          last_d     = owner;
          grant_pick = 1'b1;
        end else if (hold_cnt != HOLD_TOP) begin
          hold_d = hold_cnt + HW'(1);
        end
      end
      default: ;
    endcase
    if (grant_pick) begin
      state_d           = ST_OWN;
      gnt_d             = '0;
      gnt_d[pick_idx]   = 1'b1;
      owner_d           = pick_idx;
      hold_d            = HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt      <= '0;
      owner    <= '0;
      last_q   <= OW'(N_REQ - 1);
      hold_cnt <= '0;
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      owner    <= owner_d;
      last_q   <= last_d;
      hold_cnt <= hold_d;
    end
  end

  assign busy = |gnt;

  // Write path uses the grant that is live at this edge, so a final-cycle write still lands.
  always_comb begin
    wr_hit = 1'b0;
    wr_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i] && wr_en[i]) begin
        wr_hit = 1'b1;
        wr_sel = wr_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q  <= '0;
      wr_err <= 1'b0;
    end else begin
      if (wr_hit) reg_q <= wr_sel;
      wr_err <= |(wr_en & ~gnt);
    end
  end

endmodule
